// File: rtl/seg_display_scheduler.sv
// Four-digit seven-segment scan controller: blank gap, per-digit show window,
// shadow bank copied to the active bank atomically at the end of each frame.
module seg_display_scheduler #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       commit,
  input  logic [3:0] digit_mask,
  output logic       commit_pend,
  output logic       frame_done,
  output logic [3:0] sel,
  output logic [7:0] digit,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  state_t        state;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;
  logic [7:0]    shadow     [4];
  logic [7:0]    active     [4];
  logic [7:0]    shadow_nxt [4];
  logic          boundary;
  logic          copy_now;

  assign state_dbg = state;

  // A write landing on the copy edge must be part of the copied bank.
  always_comb begin
    for (int i = 0; i < 4; i++) shadow_nxt[i] = shadow[i];
    if (wr_en) shadow_nxt[wr_addr] = wr_data;
  end

  assign boundary = (state == SHOW) && (cnt == SHOW_LAST) && (idx == 2'd3);
  assign copy_now = (boundary && (commit_pend || commit)) || ((state == IDLE) && commit_pend);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= 8'hFF;
        active[i] <= 8'hFF;
      end
      commit_pend <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= shadow_nxt[i];
        if (copy_now) active[i] <= shadow_nxt[i];
      end
      commit_pend <= copy_now ? 1'b0 : (commit_pend | commit);
    end
  end

  // Outputs are computed from the state held this cycle, so they trail it by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 2'd0;
      cnt        <= '0;
      sel        <= 4'hF;
      digit      <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (state == SHOW) begin
        sel   <= ~(4'(digit_mask[idx]) << idx);
        digit <= digit_mask[idx] ? active[idx] : 8'hFF;
      end else begin
        sel   <= 4'hF;
        digit <= 8'hFF;
      end

      if (!enable) begin
        state <= IDLE;
        idx   <= 2'd0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= BLANK;
            idx   <= 2'd0;
            cnt   <= '0;
          end
          BLANK: begin
            if (cnt == BLANK_LAST) begin
              state <= SHOW;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          SHOW: begin
            if (cnt == SHOW_LAST) begin
              state <= BLANK;
              idx   <= idx + 2'd1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
            idx   <= 2'd0;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench for seg_display_scheduler with a frame-position reference model feeding
// an expected queue of {commit_pend, frame_done, sel, digit} per clock.
module tb_seg_display_scheduler;

  localparam int R     = 4;
  localparam int B     = 2;
  localparam int SLOT  = R + B;
  localparam int FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       commit;
  logic [3:0] digit_mask;
  logic       commit_pend;
  logic       frame_done;
  logic [3:0] sel;
  logic [7:0] digit;
  logic [1:0] state_dbg;

  seg_display_scheduler #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit      (commit),
    .digit_mask  (digit_mask),
    .commit_pend (commit_pend),
    .frame_done  (frame_done),
    .sel         (sel),
    .digit       (digit),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [13:0] exp_q[$];

  // Reference model: frame position since the scan started, and both banks.
  logic       m_run;
  int         m_k;
  logic       m_pend;
  logic [7:0] m_act [4];
  logic [7:0] m_sh  [4];

  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (pend,fd,sel,digit)", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_k    = 0;
    m_pend = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 8'hFF;
      m_sh[i]  = 8'hFF;
    end
  endtask

  // One clock: predict, push, clock, pop and compare, then drop one-cycle pulses.
  task automatic step(input string tag);
    logic [3:0]  s;
    logic [7:0]  d;
    logic        fd;
    logic        bnd;
    int          pos;
    int          dg;
    logic [13:0] e;
    s   = 4'hF;
    d   = 8'hFF;
    fd  = 1'b0;
    bnd = 1'b0;
    pos = m_k % FRAME;
    if (m_run) begin
      if ((pos % SLOT) >= B) begin
        dg = pos / SLOT;
        if (digit_mask[dg]) begin
          s = ~(4'b0001 << dg);
          d = m_act[dg];
        end
      end
      if (pos == FRAME - 1) begin
        fd  = 1'b1;
        bnd = 1'b1;
      end
    end
    if (wr_en) m_sh[wr_addr] = wr_data;
    if ((bnd && (m_pend || commit)) || (!m_run && m_pend)) begin
      for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
      m_pend = 1'b0;
    end else if (commit) begin
      m_pend = 1'b1;
    end
    if (!enable) begin
      m_run = 1'b0;
      m_k   = 0;
    end else if (m_run) begin
      m_k++;
    end else begin
      m_run = 1'b1;
      m_k   = 0;
    end
    exp_q.push_back({m_pend, fd, s, d});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(tag, {commit_pend, frame_done, sel, digit}, e);
    commit = 1'b0;
    wr_en  = 1'b0;
  endtask

  task automatic run_to_pos(input int target, input string tag);
    int guard;
    guard = 0;
    while (!(m_run && (m_k % FRAME) == target) && guard < 200) begin
      step(tag);
      guard++;
    end
    check({tag, "_reached"}, 14'(guard < 200), 14'd1);
  endtask

  logic [7:0] pats [4];
  int fd_count;

  initial begin
    pats[0] = 8'hC7; pats[1] = 8'hAF; pats[2] = 8'h83; pats[3] = 8'h8E;
    rst = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'h00;
    commit = 1'b0; digit_mask = 4'hF;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {commit_pend, frame_done, sel, digit}, 14'h0FFF);
    rst = 1'b0;

    // Disabled: dark, no frame pulses.
    repeat (10) step("idle");

    // Load patterns, commit while idle, then scan.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = pats[i];
      step("shadow_load");
    end
    commit = 1'b1;
    step("commit_idle");
    step("copy_idle");
    enable = 1'b1;
    fd_count = 0;
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      step("scan");
      if (frame_done) fd_count++;
    end
    check("frame_pulses", 14'(fd_count), 14'd2);

    // Shadow write without commit stays invisible; commit lands at the boundary.
    run_to_pos(9, "to_mid");
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h86;
    step("shadow_wr");
    repeat (3 * FRAME) step("hold");
    commit = 1'b1;
    step("commit_req");
    repeat (2 * FRAME) step("commit_frame");

    // Commit and write coinciding with the boundary edge.
    run_to_pos(FRAME - 1, "to_bnd");
    commit = 1'b1; wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h92;
    step("bnd_commit");
    repeat (FRAME) step("bnd_after");

    // Masked digits stay dark but keep their time slots.
    digit_mask = 4'b0101;
    repeat (2 * FRAME) step("mask");
    run_to_pos(12, "to_mask_mid");
    digit_mask = 4'b1011;
    repeat (FRAME) step("mask_mid");
    digit_mask = 4'hF;

    // Drop enable during digit 2 SHOW, then restart from digit 0.
    run_to_pos(15, "to_d2");
    enable = 1'b0;
    step("drop");
    repeat (5) step("idle2");
    enable = 1'b1;
    repeat (FRAME + 6) step("restart");

    // Async reset mid-SHOW with a commit pending.
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h55;
    step("pre_rst_wr");
    run_to_pos(3, "to_d0");
    commit = 1'b1;
    step("pend_set");
    step("show_d0");
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", {commit_pend, frame_done, sel, digit}, 14'h0FFF);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    commit = 1'b1;
    step("post_rst_commit");
    repeat (FRAME + 4) step("post_rst");

    check("queue_empty", 14'(exp_q.size()), 14'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
